// File: rtl/cic_interp_lite_if.sv
// Sample/strobe bundle between the upstream source, the CIC interpolator and the DAC stage.
// master drives steps and input samples; slave is the interpolator.
interface cic_interp_lite_if #(
    parameter int BITS     = 16,
    parameter int OUT_BITS = 8
);
    logic                       out_en;
    logic                       in_tick;
    logic signed [BITS-1:0]     x_in;
    logic                       in_req;
    logic signed [OUT_BITS-1:0] x_out;
    logic                       out_tick;
    logic                       underrun;
    logic                       overrun;

    modport master (
        output out_en, in_tick, x_in,
        input  in_req, x_out, out_tick, underrun, overrun
    );

    modport slave (
        input  out_en, in_tick, x_in,
        output in_req, x_out, out_tick, underrun, overrun
    );
endinterface

// File: rtl/cic_interp_lite.sv
// Two-stage CIC interpolator: low-rate comb, zero-stuff by INTERP, high-rate integrators,
// truncated signed output for a PWM/sigma-delta DAC. Paces upstream with one in_req per period.
module cic_interp_lite #(
    parameter int BITS        = 16,
    parameter int INTERP      = 64,
    parameter int LOG2_INTERP = 6,
    parameter int WIDTH       = BITS + LOG2_INTERP,
    parameter int OUT_BITS    = 8
) (
    input  logic             CLK,
    input  logic             RSTb,
    cic_interp_lite_if.slave bus
);
    localparam int CW1 = BITS + 1;
    localparam int CW2 = BITS + 2;

    logic [7:0]                 count_q, count_d;
    logic signed [BITS-1:0]     hold_q, hold_d;
    logic                       fresh_q, fresh_d;
    logic                       primed_q;
    logic signed [BITS-1:0]     s_del_q, s_del_d;
    logic signed [CW1-1:0]      c1_del_q, c1_del_d;
    logic signed [WIDTH-1:0]    integ1_q, integ1_d;
    logic signed [WIDTH-1:0]    integ2_q, integ2_d;
    logic signed [OUT_BITS-1:0] x_out_q, x_out_d;
    logic                       in_req_q, in_req_d;
    logic                       out_tick_q, out_tick_d;
    logic                       underrun_q, underrun_d;
    logic                       overrun_q, overrun_d;

    logic                       last_phase;
    logic                       consume;
    logic signed [BITS-1:0]     s_cur;
    logic signed [CW1-1:0]      c1;
    logic signed [CW2-1:0]      c2;
    logic signed [WIDTH-1:0]    inj;

    assign last_phase = (count_q == 8'(INTERP - 1));
    assign consume    = bus.out_en && (count_q == 8'd0);

    // A sample arriving in the consumption cycle bypasses the hold register.
    assign s_cur = bus.in_tick ? bus.x_in : hold_q;
    assign c1    = CW1'(s_cur) - CW1'(s_del_q);
    assign c2    = CW2'(c1) - CW2'(c1_del_q);
    assign inj   = consume ? WIDTH'(c2) : '0;

    always_comb begin
        count_d    = count_q;
        hold_d     = hold_q;
        fresh_d    = fresh_q;
        s_del_d    = s_del_q;
        c1_del_d   = c1_del_q;
        integ1_d   = integ1_q;
        integ2_d   = integ2_q;
        x_out_d    = x_out_q;
        out_tick_d = 1'b0;
        in_req_d   = !primed_q;
        underrun_d = consume && !fresh_q && !bus.in_tick;
        overrun_d  = bus.in_tick && fresh_q && !consume;

        if (bus.in_tick) begin
            hold_d = bus.x_in;
        end

        if (consume) begin
            fresh_d  = 1'b0;
            s_del_d  = s_cur;
            c1_del_d = c1;
        end else if (bus.in_tick) begin
            fresh_d = 1'b1;
        end

        if (bus.out_en) begin
            count_d    = last_phase ? 8'd0 : count_q + 8'd1;
            in_req_d   = in_req_d || last_phase;
            integ1_d   = integ1_q + inj;
            integ2_d   = integ2_q + integ1_q;
            x_out_d    = integ2_d[WIDTH-1 -: OUT_BITS];
            out_tick_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            count_q    <= '0;
            hold_q     <= '0;
            fresh_q    <= 1'b0;
            primed_q   <= 1'b0;
            s_del_q    <= '0;
            c1_del_q   <= '0;
            integ1_q   <= '0;
            integ2_q   <= '0;
            x_out_q    <= '0;
            in_req_q   <= 1'b0;
            out_tick_q <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            hold_q     <= hold_d;
            fresh_q    <= fresh_d;
            primed_q   <= 1'b1;
            s_del_q    <= s_del_d;
            c1_del_q   <= c1_del_d;
            integ1_q   <= integ1_d;
            integ2_q   <= integ2_d;
            x_out_q    <= x_out_d;
            in_req_q   <= in_req_d;
            out_tick_q <= out_tick_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.x_out    = x_out_q;
    assign bus.in_req   = in_req_q;
    assign bus.out_tick = out_tick_q;
    assign bus.underrun = underrun_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: doc/cic_interp_lite.md
Name: cic_interp_lite

Overview:
Two-stage CIC interpolator, the transmit-side counterpart of the receive-chain CIC decimator. It accepts low-rate signed samples from upstream, for example a modulator or baseband source. It runs a 2-stage comb at the low rate, zero-stuffs by INTERP, and runs a 2-stage integrator at the high rate. Output is a truncated signed sample stream for a PWM/sigma-delta DAC stage. The block paces upstream with a one-cycle request pulse per input sample.

Parameters:
BITS, 16, input sample width (signed).
INTERP, 64, interpolation ratio; power of 2, 2..256.
LOG2_INTERP, 6, log2(INTERP); must match INTERP.
WIDTH, 22, integrator width = BITS + LOG2_INTERP (growth R^(N-1), N=2, M=1).
OUT_BITS, 8, output sample width (signed).

Ports:
CLK  in  1  clock
RSTb  in  1  reset, synchronous, active-low
out_en  in  1  high-rate step strobe; may be held high continuously
in_tick  in  1  x_in valid strobe, one cycle
x_in  in  BITS  signed input sample
in_req  out  1  one-cycle pulse: upstream must supply next sample
x_out  out  OUT_BITS  signed output sample
out_tick  out  1  one-cycle pulse: x_out updated
underrun  out  1  one-cycle pulse: sample consumed with no fresh data
overrun  out  1  one-cycle pulse: fresh sample overwritten before use

Behaviour:
- Reset (RSTb=0 at a CLK edge): phase count=0, hold=0, fresh=0, comb delays=0, integ1=integ2=0. Outputs x_out=0, in_req=0, out_tick=0, underrun=0, overrun=0. Reset overrides all other inputs, including mid-period.
- Phase counter, 8 bits: on out_en, count <= (count==INTERP-1) ? 0 : count+1. It does not advance without out_en.
- in_req: registered, high for the cycle after an out_en edge where count==INTERP-1. It is also high for the first cycle after reset release, to prime the first sample.
- Input capture: in_tick writes x_in into hold and sets fresh. If fresh is already set and no consumption occurs that cycle, overrun pulses next cycle and hold is overwritten.
- Consumption: happens on an out_en cycle with count==0.
  - Consumed value s = in_tick ? x_in : hold (same-cycle bypass). fresh clears.
  - If neither fresh nor in_tick is true, hold is reused and underrun pulses the next cycle.
- Comb, evaluated combinationally at consumption and registered:
  - c1 = s - s_del, 17 bits.
  - c2 = c1 - c1_del, 18 bits.
  - s_del <= s, c1_del <= c1.
  - Comb delays update only on consumption.
- Zero-stuff injection: inj = c2 sign-extended to WIDTH when consuming, else 0.
- Integrators, updated on every out_en:
  - integ1 <= integ1 + inj.
  - integ2 <= integ2 + integ1 (uses the old integ1).
  - Wrap-around is modular two's complement; no saturation. Full-scale input cannot overflow WIDTH at steady state.
- Output: on an out_en edge, x_out <= new integ2[WIDTH-1 -: OUT_BITS] (arithmetic truncation) and out_tick <= 1. out_tick is 0 otherwise.
  - Latency: one CLK from the out_en edge to out_tick.
  - With out_en held high, out_tick stays high continuously.
- DC gain from x_in to integ2 is exactly INTERP.

Test Plan:
- Reset: assert RSTb=0 for 3 cycles mid-stream with non-zero integrators -> all outputs 0, in_req pulses once after release, count restarts at 0.
- DC step: x_in=16384 every request, out_en continuous -> integ2 ramps +16384 per step. Steady-state integ2=1048576, x_out=64 from the 64th out_tick onward; no underrun/overrun.
- Impulse: one sample 16384 then zeros -> x_out follows a triangle rising to 64 at step 64, returning to 0 by step 128, then holding at 0.
- Handshake timing: count each in_req against out_en -> exactly one in_req per INTERP out_en strobes, high only in the cycle after the count==INTERP-1 strobe.
- Underrun: withhold in_tick for one period -> underrun pulses once, held sample reused, integ2 continues as if input were repeated. Same-cycle in_tick at consumption -> bypass value used, no underrun.
- Overrun and full scale: two in_ticks before consumption -> overrun pulses, second value used. Full-scale inputs of -32768 and 32767 produce x_out=-128 and 127 in steady state with no wrap.
